// File: rtl/vip_axi4s_types_pkg.sv
// Shared AXI4-Stream types: per-field width configuration and the derived
// width of one stored beat (payload fields plus tlast).
package vip_axi4s_types_pkg;

  typedef struct packed {
    int unsigned tdata_w;
    int unsigned tstrb_w;
    int unsigned tkeep_w;
    int unsigned tid_w;
    int unsigned tdest_w;
    int unsigned tuser_w;
  } vip_axi4s_cfg_t;

  localparam vip_axi4s_cfg_t VIP_AXI4S_FIFO_DEFAULT_CFG_C = '{
    tdata_w: 32,
    tstrb_w: 4,
    tkeep_w: 4,
    tid_w:   1,
    tdest_w: 1,
    tuser_w: 1
  };

  // Stored word layout is {tlast, tuser, tdest, tid, tkeep, tstrb, tdata}.
  function automatic int unsigned vip_axi4s_payload_w(input vip_axi4s_cfg_t cfg);
    return cfg.tdata_w + cfg.tstrb_w + cfg.tkeep_w + cfg.tid_w +
           cfg.tdest_w + cfg.tuser_w + 1;
  endfunction

endpackage

// File: rtl/vip_axi4s_if.sv
// AXI4-Stream bundle. A beat transfers on a rising edge where tvalid and
// tready are both high; the source holds payload stable while tvalid && !tready.
interface vip_axi4s_if
  import vip_axi4s_types_pkg::*;
#(
  parameter vip_axi4s_cfg_t CFG_P = VIP_AXI4S_FIFO_DEFAULT_CFG_C
) ();

  logic                       tvalid;
  logic                       tready;
  logic [CFG_P.tdata_w-1:0]   tdata;
  logic [CFG_P.tstrb_w-1:0]   tstrb;
  logic [CFG_P.tkeep_w-1:0]   tkeep;
  logic                       tlast;
  logic [CFG_P.tid_w-1:0]     tid;
  logic [CFG_P.tdest_w-1:0]   tdest;
  logic [CFG_P.tuser_w-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/vip_axi4s_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the controller.
module vip_axi4s_fifo_mem #(
  parameter int unsigned W_P     = 44,
  parameter int unsigned DEPTH_P = 16,
  parameter int unsigned AW_P    = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW_P-1:0] waddr,
  input  logic [W_P-1:0]  wdata,
  input  logic [AW_P-1:0] raddr,
  output logic [W_P-1:0]  rdata
);

  logic [W_P-1:0] mem [DEPTH_P];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vip_axi4s_fifo.sv
// First-word fall-through AXI4-Stream FIFO with registered s_tready.
// Define VIP_AXI4S_FIFO_PACKET_MODE_EN for store-and-forward with pkt_count.
module vip_axi4s_fifo
  import vip_axi4s_types_pkg::*;
#(
  parameter vip_axi4s_cfg_t CFG_P   = VIP_AXI4S_FIFO_DEFAULT_CFG_C,
  parameter int unsigned    DEPTH_P = 16,
  localparam int unsigned   AW_C    = $clog2(DEPTH_P)
) (
  input  logic          clk,
  input  logic          rst_n,
  vip_axi4s_if.slave    s_axis,
  vip_axi4s_if.master   m_axis,
  output logic [AW_C:0] fill_level
`ifdef VIP_AXI4S_FIFO_PACKET_MODE_EN
  ,
  output logic [AW_C:0] pkt_count
`endif
);

  localparam int unsigned PW_C = vip_axi4s_payload_w(CFG_P);
  localparam logic [AW_C:0] FULL_C = {1'b1, {AW_C{1'b0}}};

  logic [AW_C-1:0] wr_ptr_q;
  logic [AW_C-1:0] rd_ptr_q;
  logic [AW_C:0]   fill_q;
  logic [AW_C:0]   fill_next;
  logic            s_tready_q;
  logic            wr_en;
  logic            rd_en;
  logic            m_tvalid_w;
  logic [PW_C-1:0] wr_word;
  logic [PW_C-1:0] rd_word;

  assign wr_en = s_axis.tvalid && s_tready_q;
  assign rd_en = m_tvalid_w && m_axis.tready;

  assign wr_word = {s_axis.tlast, s_axis.tuser, s_axis.tdest, s_axis.tid,
                    s_axis.tkeep, s_axis.tstrb, s_axis.tdata};
  assign {m_axis.tlast, m_axis.tuser, m_axis.tdest, m_axis.tid,
          m_axis.tkeep, m_axis.tstrb, m_axis.tdata} = rd_word;

  vip_axi4s_fifo_mem #(
    .W_P     (PW_C),
    .DEPTH_P (DEPTH_P),
    .AW_P    (AW_C)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_word),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  always_comb begin
    fill_next = fill_q;
    if (wr_en && !rd_en)      fill_next = fill_q + 1'b1;
    else if (rd_en && !wr_en) fill_next = fill_q - 1'b1;
  end

  // s_tready looks at next-cycle occupancy so a read never frees a slot
  // for a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      s_tready_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q     <= fill_next;
      s_tready_q <= (fill_next != FULL_C);
    end
  end

`ifdef VIP_AXI4S_FIFO_PACKET_MODE_EN
  logic [AW_C:0] pkt_q;
  logic          release_q;
  logic          wr_last;
  logic          rd_last;

  assign wr_last = wr_en && s_axis.tlast;
  assign rd_last = rd_en && m_axis.tlast;

  // release_q keeps an oversized packet flowing once the FIFO filled up,
  // until that packet's tlast leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q     <= '0;
      release_q <= 1'b0;
    end else begin
      if (wr_last && !rd_last)      pkt_q <= pkt_q + 1'b1;
      else if (rd_last && !wr_last) pkt_q <= pkt_q - 1'b1;
      if (rd_last)                  release_q <= 1'b0;
      else if (fill_q == FULL_C)    release_q <= 1'b1;
    end
  end

  assign m_tvalid_w = (fill_q != '0) &&
                      ((pkt_q != '0) || (fill_q == FULL_C) || release_q);
  assign pkt_count  = pkt_q;
`else
  assign m_tvalid_w = (fill_q != '0);
`endif

  assign m_axis.tvalid = m_tvalid_w;
  assign s_axis.tready = s_tready_q;
  assign fill_level    = fill_q;

endmodule

// File: tb/tb_vip_axi4s_fifo.sv
// Directed bench for vip_axi4s_fifo (DEPTH_P 16); packet-mode scenarios run
// when VIP_AXI4S_FIFO_PACKET_MODE_EN is defined.
module tb_vip_axi4s_fifo;
  import vip_axi4s_types_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = vip_axi4s_payload_w(VIP_AXI4S_FIFO_DEFAULT_CFG_C);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vip_axi4s_if s_if ();
  vip_axi4s_if m_if ();
  logic [AW:0] fill_level;
`ifdef VIP_AXI4S_FIFO_PACKET_MODE_EN
  logic [AW:0] pkt_count;
`endif

  vip_axi4s_fifo #(
    .CFG_P   (VIP_AXI4S_FIFO_DEFAULT_CFG_C),
    .DEPTH_P (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axis     (s_if.slave),
    .m_axis     (m_if.master),
    .fill_level (fill_level)
`ifdef VIP_AXI4S_FIFO_PACKET_MODE_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int n_cmp;
  int n_bad;
  int rd_cnt;
  logic last_wr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic [31:0] d, input logic last, input logic vld);
    s_if.tvalid = vld;
    s_if.tdata  = d;
    s_if.tstrb  = d[3:0];
    s_if.tkeep  = d[7:4];
    s_if.tid    = d[0];
    s_if.tdest  = d[1];
    s_if.tuser  = d[2];
    s_if.tlast  = last;
  endtask

  task automatic idle_s();
    drive_s(32'h0, 1'b0, 1'b0);
  endtask

  // One clock: score any read, record any write, then advance.
  task automatic step();
    logic [PW-1:0] got;
    last_wr = 1'b0;
    if (m_if.tvalid && m_if.tready) begin
      got = {m_if.tlast, m_if.tuser, m_if.tdest, m_if.tid,
             m_if.tkeep, m_if.tstrb, m_if.tdata};
      rd_cnt++;
      if (exp_q.size() == 0) check_eq("sb_pending", 64'(exp_q.size()), 64'd1);
      else                   check_eq("rd_beat", 64'(got), 64'(exp_q.pop_front()));
    end
    if (s_if.tvalid && s_if.tready) begin
      exp_q.push_back({s_if.tlast, s_if.tuser, s_if.tdest, s_if.tid,
                       s_if.tkeep, s_if.tstrb, s_if.tdata});
      last_wr = 1'b1;
    end
    tick();
  endtask

  task automatic drain();
    m_if.tready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) step();
    check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    m_if.tready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rd_cnt = 0;
    last_wr = 1'b0;
    rst_n = 1'b0;
    m_if.tready = 1'b0;
    idle_s();

    // reset state
    tick();
    tick();
    check_eq("rst_s_tready", 64'(s_if.tready), 64'd0);
    check_eq("rst_fill", 64'(fill_level), 64'd0);
    check_eq("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_s_tready", 64'(s_if.tready), 64'd1);

    // single beat fall-through
    drive_s(32'hA5, 1'b1, 1'b1);
    step();
    idle_s();
    check_eq("fwft_m_tvalid", 64'(m_if.tvalid), 64'd1);
    check_eq("fwft_m_tdata", 64'(m_if.tdata), 64'hA5);
    check_eq("fwft_fill", 64'(fill_level), 64'd1);
    drain();
    check_eq("fwft_fill_empty", 64'(fill_level), 64'd0);

    // simultaneous write+read at fill 1
    drive_s(32'h11, 1'b1, 1'b1);
    step();
    drive_s(32'h22, 1'b1, 1'b1);
    m_if.tready = 1'b1;
    step();
    idle_s();
    m_if.tready = 1'b0;
    check_eq("wr_rd_fill", 64'(fill_level), 64'd1);
    check_eq("wr_rd_head", 64'(m_if.tdata), 64'h22);
    drain();

    // fill to full, then drain in order
    for (int i = 0; i < 16; i++) begin
      check_eq("fill_s_tready", 64'(s_if.tready), 64'd1);
      drive_s(32'(i), 1'b1, 1'b1);
      step();
    end
    idle_s();
    check_eq("full_s_tready", 64'(s_if.tready), 64'd0);
    check_eq("full_fill", 64'(fill_level), 64'd16);
    check_eq("full_head", 64'(m_if.tdata), 64'd0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    m_if.tready = 1'b0;
    check_eq("drained_fill", 64'(fill_level), 64'd0);
    check_eq("drained_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check_eq("drained_sb", 64'(exp_q.size()), 64'd0);

    // full with write and read both pending
    for (int i = 0; i < 16; i++) begin
      drive_s(32'h100 + 32'(i), 1'b1, 1'b1);
      step();
    end
    drive_s(32'h200, 1'b1, 1'b1);
    m_if.tready = 1'b1;
    check_eq("fr_s_tready0", 64'(s_if.tready), 64'd0);
    step();
    check_eq("fr_fill1", 64'(fill_level), 64'd15);
    check_eq("fr_s_tready1", 64'(s_if.tready), 64'd1);
    step();
    idle_s();
    check_eq("fr_fill2", 64'(fill_level), 64'd15);
    drain();

    // reset mid-packet
    for (int i = 0; i < 5; i++) begin
      drive_s(32'h300 + 32'(i), 1'b0, 1'b1);
      step();
    end
    idle_s();
    check_eq("mid_fill", 64'(fill_level), 64'd5);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_fill", 64'(fill_level), 64'd0);
    check_eq("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check_eq("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    check_eq("mid_rel_s_tready", 64'(s_if.tready), 64'd1);
    drive_s(32'h77, 1'b1, 1'b1);
    step();
    idle_s();
    check_eq("mid_next_m_tvalid", 64'(m_if.tvalid), 64'd1);
    check_eq("mid_next_m_tdata", 64'(m_if.tdata), 64'h77);
    drain();

`ifdef VIP_AXI4S_FIFO_PACKET_MODE_EN
    // store-and-forward of a 4-beat packet
    for (int i = 1; i <= 4; i++) begin
      drive_s(32'h40 + 32'(i), (i == 4), 1'b1);
      step();
      if (i < 4) check_eq("pkt_hold_m_tvalid", 64'(m_if.tvalid), 64'd0);
    end
    idle_s();
    check_eq("pkt_m_tvalid", 64'(m_if.tvalid), 64'd1);
    check_eq("pkt_count1", 64'(pkt_count), 64'd1);
    drain();
    check_eq("pkt_count0", 64'(pkt_count), 64'd0);

    // 20-beat packet released at full
    begin
      int idx;
      int rd0;
      for (int i = 0; i < 16; i++) begin
        drive_s(32'h500 + 32'(i), 1'b0, 1'b1);
        step();
      end
      check_eq("big_full_fill", 64'(fill_level), 64'd16);
      check_eq("big_full_m_tvalid", 64'(m_if.tvalid), 64'd1);
      check_eq("big_full_pkt", 64'(pkt_count), 64'd0);
      idx = 16;
      rd0 = rd_cnt;
      m_if.tready = 1'b1;
      for (int c = 0; c < 200 && (rd_cnt - rd0) < 20; c++) begin
        if (idx < 20) drive_s(32'h500 + 32'(idx), (idx == 19), 1'b1);
        else          idle_s();
        step();
        if (last_wr) idx++;
      end
      idle_s();
      m_if.tready = 1'b0;
      check_eq("big_written", 64'(idx), 64'd20);
      check_eq("big_read", 64'(rd_cnt - rd0), 64'd20);
      check_eq("big_pkt_end", 64'(pkt_count), 64'd0);
      check_eq("big_sb", 64'(exp_q.size()), 64'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
